// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and helpers for the LCD text overlay renderer.
package lcd_pkg;
  localparam int ADDR_W = 11;
  typedef logic [23:0] rgb_t;
  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} commit_state_e;
  function automatic int clog2(input int n);
    return $clog2(n);
  endfunction
  // Index ports need at least one bit even for a single-character line.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lcd_text_delay.sv
// lcd_text_delay: fixed-depth shift register carrying pixel side-band past the font ROM.
module lcd_text_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr_q [DEPTH];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end
  assign q = sr_q[DEPTH-1];
endmodule

// File: rtl/lcd_text_render.sv
// lcd_text_render: scaled glyph-row overlay with tear-free double-buffered character codes.
module lcd_text_render
  import lcd_pkg::*;
#(
  parameter int GLYPH_W    = 8,
  parameter int GLYPH_H    = 16,
  parameter int NUM_CHARS  = 8,
  parameter int CHAR_BITS  = 7,
  parameter int SCALE_LOG2 = 1,
  parameter int X0         = 16,
  parameter int Y0         = 16,
  parameter rgb_t FG       = 24'hFFFFFF,
  parameter rgb_t BG       = 24'h000000,
  parameter int ROM_LAT    = 1,
  parameter logic [CHAR_BITS-1:0] SPACE_CODE = 7'h20
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   ready_sig,
  input  logic [ADDR_W-1:0]                      column_addr_sig,
  input  logic [ADDR_W-1:0]                      row_addr_sig,
  input  logic                                   wr_en,
  input  logic [idx_w(NUM_CHARS)-1:0]            wr_idx,
  input  logic [CHAR_BITS-1:0]                   wr_char,
  input  logic                                   commit,
  output logic                                   commit_pending,
  output logic [CHAR_BITS+clog2(GLYPH_H)-1:0]    rom_addr,
  input  logic [GLYPH_W-1:0]                     rom_data,
  output logic [7:0]                             red_sig,
  output logic [7:0]                             green_sig,
  output logic [7:0]                             blue_sig,
  output logic                                   pix_valid
);
  localparam int IW  = idx_w(NUM_CHARS);
  localparam int GXW = clog2(GLYPH_W);
  localparam int GYW = clog2(GLYPH_H);
  localparam int DW  = GXW + 2;
  localparam logic [11:0] X_LO = 12'(X0);
  localparam logic [11:0] X_HI = 12'(X0 + ((NUM_CHARS * GLYPH_W) << SCALE_LOG2));
  localparam logic [11:0] Y_LO = 12'(Y0);
  localparam logic [11:0] Y_HI = 12'(Y0 + (GLYPH_H << SCALE_LOG2));

  logic [ADDR_W-1:0] dx, dy, sx;
  logic in_box, frame_start, swap;
  commit_state_e state_q, state_d;
  logic s0_rdy_q, s0_box_q;
  logic [IW-1:0] s0_idx_q;
  logic [GXW-1:0] s0_gx_q;
  logic [GYW-1:0] s0_gy_q;
  logic [CHAR_BITS-1:0] shadow_q [NUM_CHARS];
  logic [CHAR_BITS-1:0] active_q [NUM_CHARS];
  logic [CHAR_BITS-1:0] code;
  logic [CHAR_BITS+GYW-1:0] rom_addr_q;
  logic [DW-1:0] dly;
  logic [GLYPH_W-1:0] sh;
  rgb_t pix_d, pix_q;
  logic valid_q;

  // Comparisons run in 12 bits so the box end never wraps near the 11-bit limit.
  assign in_box = {1'b0, column_addr_sig} >= X_LO && {1'b0, column_addr_sig} < X_HI &&
                  {1'b0, row_addr_sig} >= Y_LO && {1'b0, row_addr_sig} < Y_HI;
  assign dx = column_addr_sig - ADDR_W'(X0);
  assign dy = row_addr_sig - ADDR_W'(Y0);
  assign sx = dx >> SCALE_LOG2;
  assign frame_start = ready_sig && column_addr_sig == '0 && row_addr_sig == '0;
  assign swap = frame_start && (state_q == PENDING || commit);

  always_comb begin
    state_d = swap ? IDLE : (commit ? PENDING : state_q);
    code = (int'(s0_idx_q) < NUM_CHARS) ? active_q[s0_idx_q] : SPACE_CODE;
    sh = rom_data << dly[GXW-1:0];
    pix_d = (dly[DW-1] && dly[DW-2]) ? (sh[GLYPH_W-1] ? FG : BG) : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      s0_rdy_q <= 1'b0;
      s0_box_q <= 1'b0;
      s0_idx_q <= '0;
      s0_gx_q <= '0;
      s0_gy_q <= '0;
      rom_addr_q <= '0;
      pix_q <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < NUM_CHARS; i++) begin
        shadow_q[i] <= SPACE_CODE;
        active_q[i] <= SPACE_CODE;
      end
    end else begin
      state_q <= state_d;
      s0_rdy_q <= ready_sig;
      s0_box_q <= in_box;
      s0_idx_q <= IW'(sx >> GXW);
      s0_gx_q <= GXW'(sx);
      s0_gy_q <= GYW'(dy >> SCALE_LOG2);
      rom_addr_q <= {code, s0_gy_q};
      pix_q <= pix_d;
      valid_q <= dly[DW-1];
      // Swap copies the pre-write shadow; a same-cycle write lands in shadow only.
      if (swap) active_q <= shadow_q;
      if (wr_en && int'(wr_idx) < NUM_CHARS) shadow_q[wr_idx] <= wr_char;
    end
  end

  lcd_text_delay #(.W(DW), .DEPTH(ROM_LAT + 1)) u_dly (
    .clk (clk),
    .rstn(rstn),
    .d   ({s0_rdy_q, s0_box_q, s0_gx_q}),
    .q   (dly)
  );

  assign commit_pending = state_q == PENDING;
  assign rom_addr = rom_addr_q;
  assign red_sig = pix_q[23:16];
  assign green_sig = pix_q[15:8];
  assign blue_sig = pix_q[7:0];
  assign pix_valid = valid_q;
endmodule

// File: tb/tb_lcd_text_render.sv
// tb_lcd_text_render: scoreboard bench with directed pixels, commits and mid-line reset.
module tb_lcd_text_render;
  localparam int L = 3;
  localparam logic [23:0] FGC = 24'hFFFFFF;
  localparam logic [23:0] BGC = 24'h204060;
  typedef struct {
    int          due;
    logic [31:0] exp;
    string       name;
  } item_t;

  logic clk = 0, rstn = 0, ready_sig = 0, wr_en = 0, commit = 0;
  logic [10:0] col = 0, row = 0;
  logic [2:0] wr_idx = 0;
  logic [6:0] wr_char = 0;
  logic commit_pending, pix_valid;
  logic [10:0] rom_addr;
  logic [7:0] rom_data, red, green, blue;
  int cyc = 0, n_vec = 0, n_bad = 0;
  item_t sb[3][$];
  logic [6:0] m_act[8], m_shd[8];
  bit m_pend;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] font(input logic [6:0] code, input logic [3:0] r);
    return code == 7'h20 ? 8'h00 : (r == 4'd0 ? 8'h80 : ({1'b0, code} ^ {r, r}));
  endfunction

  always @(posedge clk) rom_data <= font(rom_addr[10:4], rom_addr[3:0]);

  lcd_text_render #(.BG(BGC)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .ready_sig      (ready_sig),
    .column_addr_sig(col),
    .row_addr_sig   (row),
    .wr_en          (wr_en),
    .wr_idx         (wr_idx),
    .wr_char        (wr_char),
    .commit         (commit),
    .commit_pending (commit_pending),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .red_sig        (red),
    .green_sig      (green),
    .blue_sig       (blue),
    .pix_valid      (pix_valid)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      while (sb[k].size() > 0 && sb[k][0].due <= cyc) begin
        item_t it;
        logic [31:0] a;
        it = sb[k].pop_front();
        a = k == 0 ? {7'b0, pix_valid, red, green, blue} : (k == 1 ? 32'(rom_addr) : 32'(commit_pending));
        if (it.due != cyc) begin
          n_bad++;
          $display("FAIL %s: check missed at cycle %0d, due %0d", it.name, cyc, it.due);
        end else chk(it.name, a, it.exp);
      end
    end
  end

  task automatic px(input int c, input int r, input bit rdy, input bit we = 0, input int wi = 0,
                    input logic [6:0] wc = 0, input bit cm = 0);
    bit inb;
    int dx, dy, idx, gx, gy;
    logic [7:0] bits;
    logic [23:0] rgb;
    item_t it;
    col = 11'(c); row = 11'(r); ready_sig = rdy; wr_en = we; wr_idx = 3'(wi); wr_char = wc; commit = cm;
    if (rdy && c == 0 && r == 0 && (m_pend || cm)) begin
      m_act = m_shd;
      m_pend = 0;
    end else if (cm) m_pend = 1;
    inb = c >= 16 && c < 144 && r >= 16 && r < 48;
    dx = c - 16; dy = r - 16; idx = dx / 16; gx = (dx / 2) % 8; gy = dy / 2;
    rgb = 24'h0;
    if (inb) begin
      bits = font(m_act[idx], 4'(gy));
      rgb = bits[7-gx] ? FGC : BGC;
      it.due = cyc + 2; it.exp = 32'({m_act[idx], 4'(gy)}); it.name = $sformatf("rom_addr(%0d,%0d)", c, r);
      sb[1].push_back(it);
    end
    it.due = cyc + 1 + L; it.exp = {7'b0, rdy, rdy ? rgb : 24'h0};
    it.name = $sformatf("pix(%0d,%0d,rdy=%0d)", c, r, rdy);
    sb[0].push_back(it);
    it.due = cyc + 1; it.exp = 32'(m_pend); it.name = $sformatf("commit_pending@(%0d,%0d)", c, r);
    sb[2].push_back(it);
    if (we && wi < 8) m_shd[wi] = wc;
    @(posedge clk); #1;
    ready_sig = 0; wr_en = 0; commit = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_act[i] = 7'h20;
      m_shd[i] = 7'h20;
    end
    m_pend = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset rgb", {8'b0, red, green, blue}, 32'h0);
    chk("reset pix_valid", 32'(pix_valid), 32'h0);
    chk("reset rom_addr", 32'(rom_addr), 32'h0);
    chk("reset commit_pending", 32'(commit_pending), 32'h0);
    rstn = 1;
    // Blank frame: spaces everywhere, box edges, ready low.
    px(0, 0, 1); px(16, 16, 1); px(17, 16, 1); px(15, 16, 1); px(143, 16, 1);
    px(144, 16, 1); px(16, 47, 1); px(16, 48, 1); px(16, 16, 0);
    // Shadow writes and a mid-frame commit that must wait for the next frame start.
    px(20, 20, 0, 1, 0, 7'h41); px(20, 20, 0, 1, 7, 7'h43);
    px(30, 20, 1, 0, 0, 7'h00, 1); px(16, 16, 1); px(64, 30, 1);
    px(0, 0, 1); px(16, 16, 1); px(17, 16, 1); px(16, 17, 1); px(17, 17, 1); px(18, 16, 1);
    px(22, 26, 1); px(30, 26, 1); px(128, 16, 1); px(143, 16, 1); px(144, 16, 1);
    px(15, 16, 1); px(16, 47, 1); px(16, 48, 1);
    // Commit and write to slot 3 on the frame-start pixel.
    px(0, 0, 1, 1, 3, 7'h42, 1); px(64, 16, 1);
    px(5, 5, 1, 0, 0, 7'h00, 1); px(64, 16, 1); px(0, 0, 1); px(64, 16, 1);
    // Mid-line reset with lit pixels in flight.
    px(16, 16, 1); px(16, 16, 1); px(16, 16, 1); px(16, 16, 1);
    chk("pre-reset rgb", {8'b0, red, green, blue}, {8'b0, FGC});
    #1 rstn = 0;
    #1;
    chk("async reset rgb", {8'b0, red, green, blue}, 32'h0);
    chk("async reset pix_valid", 32'(pix_valid), 32'h0);
    chk("async reset rom_addr", 32'(rom_addr), 32'h0);
    chk("async reset commit_pending", 32'(commit_pending), 32'h0);
    for (int k = 0; k < 3; k++) sb[k].delete();
    model_reset();
    @(posedge clk); #1;
    rstn = 1;
    px(16, 16, 1); px(3, 3, 1, 0, 0, 7'h00, 1); px(0, 0, 1); px(16, 16, 1); px(128, 16, 1);
    for (int i = 0; i < 20 && (sb[0].size() + sb[1].size() + sb[2].size()) > 0; i++) @(posedge clk);
    @(posedge clk);
    if ((sb[0].size() + sb[1].size() + sb[2].size()) > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected responses never checked", sb[0].size() + sb[1].size() + sb[2].size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
